// File: rtl/byte_fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | byte_fifo_pkg : shared constants and helpers for the byte FIFO       |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
package byte_fifo_pkg;

    localparam int BYTE_W        = 8;
    localparam int DEPTH_DEFAULT = 4;

    // Pointer width for a power-of-two depth (depth >= 2).
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/byte_fifo_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | byte_fifo_if : producer/consumer handshake bundle of the byte FIFO   |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
interface byte_fifo_if #(
    parameter int WIDTH = byte_fifo_pkg::BYTE_W,
    parameter int DEPTH = byte_fifo_pkg::DEPTH_DEFAULT
) ();
    import byte_fifo_pkg::*;

    localparam int AW = ptr_w(DEPTH);

    logic             clr;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [AW:0]      count;
    logic             overflow;

    modport master (
        output clr, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, count, overflow
    );

    modport slave (
        input  clr, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, count, overflow
    );
endinterface
`default_nettype wire

// File: rtl/byte_fifo_ptr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | byte_fifo_ptr : modulo-DEPTH pointer register with inc and clr       |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
module byte_fifo_ptr #(
    parameter int AW = 2
) (
    input  wire           clk,
    input  wire           rst,
    input  wire           clr,
    input  wire           inc,
    output logic [AW-1:0] ptr
);
    logic [AW-1:0] r_ptr;

    // Power-of-two depth: natural binary overflow gives the modulo wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (clr) begin
            r_ptr <= '0;
        end else if (inc) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

    assign ptr = r_ptr;
endmodule
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | byte_fifo : first-word fall-through circular byte FIFO with sticky   |
// |             overflow flag and occupancy count                        |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module byte_fifo #(
    parameter int WIDTH = byte_fifo_pkg::BYTE_W,
    parameter int DEPTH = byte_fifo_pkg::DEPTH_DEFAULT
) (
    input wire         clk,
    input wire         rst,
    byte_fifo_if.slave bus
);
    import byte_fifo_pkg::*;

    localparam int          AW     = ptr_w(DEPTH);
    localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_count;
    logic             r_overflow;
    logic [AW-1:0]    w_wr_ptr;
    logic [AW-1:0]    w_rd_ptr;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    // Flags come only from the registered count, so no input-to-output path.
    assign w_full  = (r_count == C_FULL);
    assign w_empty = (r_count == '0);
    assign w_push  = bus.in_valid  & ~w_full  & ~bus.clr;
    assign w_pop   = bus.out_ready & ~w_empty & ~bus.clr;

    byte_fifo_ptr #(.AW(AW)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (bus.clr),
        .inc (w_push),
        .ptr (w_wr_ptr)
    );

    byte_fifo_ptr #(.AW(AW)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (bus.clr),
        .inc (w_pop),
        .ptr (w_rd_ptr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem <= '{default: '0};
        end else if (w_push) begin
            r_mem[w_wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (bus.clr) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A byte offered during a flush is dropped silently, not flagged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (bus.clr) begin
            r_overflow <= 1'b0;
        end else if (bus.in_valid & w_full) begin
            r_overflow <= 1'b1;
        end
    end

    assign bus.in_ready  = ~w_full;
    assign bus.out_valid = ~w_empty;
    assign bus.out_data  = r_mem[w_rd_ptr];
    assign bus.count     = r_count;
    assign bus.overflow  = r_overflow;
endmodule
`default_nettype wire
